// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory,
// captures the returned words in a small FIFO and hands them to the decoder
// in issue order. A redirect flushes the queue and restarts fetch at a new PC.
// Optional build macro: IFQ_PERF_CNT_EN adds saturating flush/stall counters.
module instr_fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       enable,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_ren,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     level
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]                flush_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int OCC_W = LVL_W + 1;

    // Control state
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_infl_pc;
    logic              r_inflight;
    logic [LVL_W-1:0]  r_level;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;

    // Queue storage (no reset needed; contents gated by level)
    logic [DEPTH-1:0][DATA_W-1:0] r_mem_instr;
    logic [DEPTH-1:0][ADDR_W-1:0] r_mem_pc;

    logic             w_flush;
    logic             w_pop;
    logic             w_wr;
    logic             w_credit;
    logic [OCC_W-1:0] w_occ;

    // Credit counts entries held plus the one fetch that may still be returning;
    // only registered state is used, so a same-cycle pop never frees a slot early.
    assign w_occ    = OCC_W'(r_level) + OCC_W'(r_inflight);
    assign w_credit = w_occ < OCC_W'(DEPTH);

    assign w_flush  = enable & redirect;
    assign imem_ren = arst_n & enable & ~redirect & w_credit;
    assign imem_addr = r_fetch_pc;

    assign out_valid = enable & (r_level != '0);
    assign out_instr = r_mem_instr[r_rptr];
    assign out_pc    = r_mem_pc[r_rptr];
    assign level     = r_level;

    assign w_pop = out_valid & out_ready;
    // Returning data lands even when frozen; only a live redirect discards it.
    assign w_wr  = r_inflight & ~w_flush;

    // Fetch PC, in-flight tracking, pointers and occupancy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_fetch_pc <= RESET_PC;
            r_infl_pc  <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (w_flush) begin
            // A same-cycle pop is simply absorbed by the flush.
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_level    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_inflight <= imem_ren;
            if (imem_ren) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_INC);
                r_infl_pc  <= r_fetch_pc;
            end
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
        end
    end

    // Tail write of the returned word and the PC that fetched it
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_instr[r_wptr] <= imem_rdata;
            r_mem_pc[r_wptr]    <= r_infl_pc;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating event counters: taken redirects and head-blocked cycles
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign flush_cnt = r_flush_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios followed by
// random traffic, all checked every cycle against a queue-based reference.
// Build with IFQ_PERF_CNT_EN defined to also check the perf counters.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  level;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] flush_cnt;
    logic [31:0] stall_cnt;
`endif

    instr_fetch_queue dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .level       (level)
`ifdef IFQ_PERF_CNT_EN
        ,
        .flush_cnt   (flush_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a word derived from its address (equals the address below 4 GiB)
    function automatic logic [31:0] memw(input logic [63:0] a);
        return a[31:0] ^ a[63:32];
    endfunction

    // One-cycle-latency instruction memory
    always @(posedge clk) begin
        if (imem_ren)
            imem_rdata <= memw(imem_addr);
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: the queue holds PCs in issue order
    logic [63:0] m_q[$];
    logic [63:0] m_fpc;
    bit          m_infl;
    logic [63:0] m_infl_pc;
    int unsigned m_flush;
    int unsigned m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc     = 64'h0;
        m_infl    = 1'b0;
        m_infl_pc = 64'h0;
        m_flush   = 0;
        m_stall   = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, check, advance the model
    task automatic step(input bit en, input bit rd, input logic [63:0] rpc, input bit rdy);
        bit exp_ren;
        bit exp_valid;
        enable      = en;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        #1;
        exp_ren   = en && !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
        exp_valid = en && (m_q.size() != 0);
        chk("imem_ren",  {63'd0, imem_ren},  {63'd0, exp_ren});
        chk("imem_addr", imem_addr, m_fpc);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        chk("level",     {61'd0, level}, 64'(m_q.size()));
        if (exp_valid) begin
            chk("out_pc",    out_pc, m_q[0]);
            chk("out_instr", {32'd0, out_instr}, {32'd0, memw(m_q[0])});
        end
`ifdef IFQ_PERF_CNT_EN
        chk("flush_cnt", {32'd0, flush_cnt}, 64'(m_flush));
        chk("stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
`endif
        if (exp_valid && rdy)
            void'(m_q.pop_front());
        if (m_infl && !(en && rd))
            m_q.push_back(m_infl_pc);
        if (exp_valid && !rdy)
            m_stall++;
        if (en && rd) begin
            m_q.delete();
            m_fpc  = rpc;
            m_infl = 1'b0;
            m_flush++;
        end else begin
            m_infl = exp_ren;
            if (exp_ren) begin
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren"},   {63'd0, imem_ren},  64'd0);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_level"}, {61'd0, level},     64'd0);
        chk({tag, "_addr"},  imem_addr,          64'd0);
`ifdef IFQ_PERF_CNT_EN
        chk({tag, "_flush"}, {32'd0, flush_cnt}, 64'd0);
        chk({tag, "_stall"}, {32'd0, stall_cnt}, 64'd0);
`endif
    endtask

    initial begin
        arst_n      = 1'b0;
        enable      = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        out_ready   = 1'b1;
        model_reset();
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;

        // Streaming with a word-equals-address memory
        for (int i = 0; i < 10; i++) step(1, 0, 64'h0, 1);

        // Backpressure until full, then drain
        for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 1);

        // Redirect with level=3 and a fetch in flight
        step(1, 1, 64'h0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);
        step(1, 1, 64'h100, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 64'h0, 1);

        // Redirect coinciding with a pop of head PC 0x8
        step(1, 1, 64'h0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);
        for (int i = 0; i < 6 && m_q.size() != 0 && m_q[0] != 64'h8; i++)
            step(1, 0, 64'h0, 1);
        chk("head_is_8", (m_q.size() != 0) ? m_q[0] : 64'hdead, 64'h8);
        step(1, 1, 64'h100, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 64'h0, 1);

        // Freeze with data in flight, then resume
        for (int i = 0; i < 3; i++) step(0, 0, 64'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 64'h400, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 1);

        // Five stall cycles and a second round of redirects
        for (int i = 0; i < 5; i++) step(1, 0, 64'h0, 0);
        step(1, 1, 64'h2000, 0);
        step(1, 1, 64'h3000, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 64'h0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] rpc;
            rpc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 1) == 0) rpc = rpc & 64'hFFFF_FFFC;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, rpc,
                 $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of streaming
        for (int i = 0; i < 4; i++) step(1, 0, 64'h0, 0);
        enable    = 1'b1;
        out_ready = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, 64'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
